// File: rtl/fnd_num_if.sv
// Value handshake between the FND register block (master) and the scan
// sequencer (slave).
// Handshake: the master raises num_valid with num_data and holds both stable
// until it sees num_ready high at a rising PCLK edge. The transfer happens on
// that edge. num_ready never depends combinationally on num_valid.
interface fnd_num_if;
  logic        num_valid;
  logic [13:0] num_data;
  logic        num_ready;

  modport master (output num_valid, output num_data, input num_ready);
  modport slave  (input num_valid, input num_data, output num_ready);
endinterface

// File: rtl/fnd_scan_sequencer.sv
// 4-digit common-anode FND sequencer: binary value -> BCD by an iterative
// double-dabble FSM, then time-multiplexed digit scan with a blanking guard,
// leading-zero suppression and per-digit decimal point.
module fnd_scan_sequencer #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_CYC   = 64
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  fnd_num_if.slave    num,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  fndCom,
  output logic [7:0]  fndFont,
  output logic [1:0]  conv_state
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_COMMIT = 2'd2} state_t;

  state_t      state, next_state;
  logic        accept;
  logic        ready_q;
  logic [13:0] sh;
  logic [15:0] bcd, bcd_adj;
  logic [3:0]  cnt;
  logic        ovf_cap;
  logic [15:0] disp;
  logic        overflow_q;

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [3:0]       cur_digit;
  logic             lz_zero;
  logic [6:0]       font_seg;
  logic             lit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign num.num_ready = ready_q;
  assign busy          = (state != ST_IDLE);
  assign overflow      = overflow_q;
  assign conv_state    = state;

  // Converter next-state: accept only while idle and ready, 14 shifts, one commit.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (num.num_valid && ready_q) begin
          accept     = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT:  if (cnt == 4'd13) next_state = ST_COMMIT;
      ST_COMMIT: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble >= 5 ahead of the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Converter state and datapath; the display copy is taken in one cycle so the scan never sees partial digits.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b0;
      sh         <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf_cap    <= 1'b0;
      disp       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == ST_IDLE);
      if (accept) begin
        sh      <= num.num_data;
        bcd     <= '0;
        cnt     <= '0;
        ovf_cap <= (num.num_data > 14'd9999);
      end else if (state == ST_SHIFT) begin
        bcd <= {bcd_adj[14:0], sh[13]};
        sh  <= {sh[12:0], 1'b0};
        cnt <= cnt + 4'd1;
      end else if (state == ST_COMMIT) begin
        disp       <= bcd;
        overflow_q <= ovf_cap;
      end
    end
  end

  // Slot divider and digit index; disabling parks both at zero.
  always_ff @(posedge PCLK) begin
    if (!PRESET || !enable) begin
      div <= '0;
      idx <= 2'd0;
    end else if (div == DIV_W'(REFRESH_DIV - 1)) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Segment pattern for the current slot: dashes on overflow, else LZ blank or digit.
  always_comb begin
    cur_digit = disp[4*idx +: 4];
    case (idx)
      2'd1:    lz_zero = (disp[15:4] == 12'd0);
      2'd2:    lz_zero = (disp[15:8] == 8'd0);
      2'd3:    lz_zero = (disp[15:12] == 4'd0);
      default: lz_zero = 1'b0;
    endcase
    if (overflow_q)               font_seg = 7'h3F;
    else if (blank_lz && lz_zero) font_seg = 7'h7F;
    else                          font_seg = seg7(cur_digit);
    lit = enable && (div >= DIV_W'(BLANK_CYC));
  end

  // Registered pin drivers; everything dark during the guard interval.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      fndCom  <= 4'hF;
      fndFont <= 8'hFF;
    end else if (lit) begin
      fndCom  <= ~(4'b0001 << idx);
      fndFont <= {~dp_mask[idx], font_seg};
    end else begin
      fndCom  <= 4'hF;
      fndFont <= 8'hFF;
    end
  end

endmodule
